sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Memory-side responder for the core's load/store path.
- Accepts 32-bit word requests from the MEM-stage LSU over a valid/ready handshake.
- Serves each request as two 16-bit accesses to the board's external asynchronous SRAM (256K x 16, CE/WE/OE/LB/UB strobes, bidirectional DQ).
- Returns one response pulse per request: read data for reads, completion for writes.

Parameters:
ADDR_W, 18, SRAM halfword address width
RD_WAIT, 1, cycles each read half holds address/OE before DQ is sampled; legal range >=1
WR_WAIT, 1, cycles WE_n is held low per write half; legal range >=1

Ports:
i_clk  in  1  global clock; all state changes on rising edge
i_rstn  in  1  reset, asynchronous, active-low
i_req_vld  in  1  request valid from LSU
o_req_rdy  out  1  controller idle and accepting a request
i_req_wren  in  1  1 = write, 0 = read
i_req_addr  in  32  byte address; bits [1:0] and bits above ADDR_W are ignored
i_req_wdata  in  32  store data
i_req_bmask  in  4  byte enables for writes; ignored for reads
o_rsp_vld  out  1  one-cycle pulse: read data valid or write complete
o_rsp_rdata  out  32  read data; held until the next read completes
o_sram_addr  out  ADDR_W  SRAM halfword address
io_sram_dq  inout  16  SRAM data bus
o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active-low

Behaviour:
- Reset values (applied asynchronously):
  - state = IDLE, o_req_rdy = 1, o_rsp_vld = 0, o_rsp_rdata = 0, o_sram_addr = 0.
  - All SRAM strobes = 1.
  - DQ released (high-Z).
- States: IDLE -> LO -> HI -> RSP -> IDLE.
  - o_req_rdy is 1 only in IDLE.
  - A request is accepted when i_req_vld & o_req_rdy.
  - On acceptance, addr, wdata, bmask and wren are latched. Request inputs are not sampled at any other time.
  - i_req_vld while busy is ignored; the requester holds the request until ready.
- Address mapping: LO uses o_sram_addr = {i_req_addr[ADDR_W:2], 1'b0}; HI uses {i_req_addr[ADDR_W:2], 1'b1}.
- All strobes and o_sram_addr are registered and updated with the state register, so they are glitch-free.
- Read phase (RD_WAIT cycles):
  - CE_n = 0, OE_n = 0, WE_n = 1, LB_n = UB_n = 0, DQ released.
  - DQ is sampled on the last cycle of the phase: LO fills rdata[15:0], HI fills rdata[31:16].
  - Reads always perform both halves.
- Write phase (WR_WAIT+1 cycles):
  - CE_n = 0, OE_n = 1 throughout.
  - WE_n = 0 for the first WR_WAIT cycles, then 1 for one hold cycle.
  - Address and DQ are driven for the whole phase.
  - DQ = wdata[15:0] in LO, wdata[31:16] in HI.
  - LO: LB_n = ~bmask[0], UB_n = ~bmask[1]. HI: LB_n = ~bmask[2], UB_n = ~bmask[3].
- Write skip rules:
  - bmask[1:0] == 0 skips LO.
  - bmask[3:2] == 0 skips HI.
  - bmask == 0 goes directly IDLE -> RSP, with no strobe activity.
- Phase counter: cleared on phase entry; the phase ends when the count reaches its limit.
- RSP state: one cycle with o_rsp_vld = 1; on reads, o_rsp_rdata is updated to the assembled word; then returns to IDLE.
  - The next request can be accepted in the cycle after RSP.
- Latency from the acceptance cycle t:
  - Read: o_rsp_vld at t + 2*RD_WAIT + 1.
  - Full write: t + 2*(WR_WAIT+1) + 1.
  - Single-half write: t + (WR_WAIT+1) + 1.
  - Empty-mask write: t + 1.
- Between phases (LO -> HI): the address changes only when WE_n = 1, and the DQ driver stays enabled across the two write halves.
- Reset mid-operation:
  - Strobes deassert and DQ is released immediately.
  - The pending request is dropped with no o_rsp_vld.
  - After release the controller is in IDLE with o_req_rdy = 1.

Decomposition:
- Package sram_pkg:
  - state enum (IDLE, LO, HI, RSP).
  - SRAM_DW = 16.
  - idle strobe constant (all ones).
- Sub-module sram_dq_buf: tristate driver (output enable, 16-bit out data) plus a 16-bit input view of DQ. It isolates the inout from the FSM for simulation and synthesis.

Test Plan:
1. Reset check: assert i_rstn = 0 -> o_req_rdy = 1, o_rsp_vld = 0, o_sram_addr = 0, all strobes = 1, DQ = Z.
2. Full write, default parameters: write 0xDEADBEEF to 0x0000_0010, bmask 1111 -> SRAM model sees:
   - 0xBEEF at 0x00008, then 0xDEAD at 0x00009, each with LB_n = UB_n = 0 and WE_n low for 1 cycle;
   - o_rsp_vld at t+5.
3. Read back 0x0000_0010 -> o_rsp_rdata = 0xDEADBEEF, o_rsp_vld at t+3, DQ never driven by the DUT, OE_n = 0 for both halves.
4. Byte write: bmask 0100, wdata 0x00AA_0000 to 0x10 -> only HI phase, addr 0x00009, LB_n = 0, UB_n = 1, o_rsp_vld at t+3; subsequent read returns 0xDEAABEEF.
5. Empty mask and parameters:
   - bmask 0000 write -> no CE_n activity, o_rsp_vld at t+1.
   - With RD_WAIT = 3, a read returns its response at t+7.
6. Reset during the HI phase of a read -> strobes high and DQ = Z the same cycle, no o_rsp_vld; after release, a new write/read pair completes correctly.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the LSU-to-external-SRAM controller.
package sram_pkg;

  localparam int unsigned SRAM_DW = 16;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BE_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RSP  = 2'd3
  } state_e;

  typedef struct packed {
    logic ce_n;
    logic we_n;
    logic oe_n;
    logic lb_n;
    logic ub_n;
  } strb_t;

  localparam strb_t STRB_IDLE = '1;

  typedef struct packed {
    logic              wren;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   bmask;
  } req_t;

  // Active-low {ub_n, lb_n} for the selected halfword of a 4-bit byte mask.
  function automatic logic [1:0] lane_n(input logic [BE_W-1:0] bmask, input logic hi);
    return hi ? ~bmask[3:2] : ~bmask[1:0];
  endfunction

endpackage

// File: rtl/sram_if.sv
// LSU-side request/response handshake between the MEM stage and sram_ctrl.
interface sram_if;
  import sram_pkg::*;

  logic              req_vld;
  logic              req_rdy;
  logic              req_wren;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_bmask;
  logic              rsp_vld;
  logic [WORD_W-1:0] rsp_rdata;

  modport master (
    output req_vld, req_wren, req_addr, req_wdata, req_bmask,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wren, req_addr, req_wdata, req_bmask,
    output req_rdy, rsp_vld, rsp_rdata
  );
endinterface

// File: rtl/sram_dq_buf.sv
// Tristate driver and input view for the bidirectional SRAM data bus.
module sram_dq_buf
  import sram_pkg::*;
(
  input  logic               i_oe,
  input  logic [SRAM_DW-1:0] i_dout,
  output logic [SRAM_DW-1:0] o_din,
  inout  wire  [SRAM_DW-1:0] io_dq
);

  assign io_dq = i_oe ? i_dout : {SRAM_DW{1'bz}};
  assign o_din = io_dq;

endmodule

// File: rtl/sram_ctrl.sv
// Serves 32-bit LSU loads/stores as two 16-bit accesses to an async SRAM.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  sram_if.slave              lsu,
  output logic [ADDR_W-1:0]  o_sram_addr,
  inout  wire  [SRAM_DW-1:0] io_sram_dq,
  output logic               o_sram_ce_n,
  output logic               o_sram_we_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_lb_n,
  output logic               o_sram_ub_n
);

  localparam int unsigned HA_W     = ADDR_W - 1;
  localparam int unsigned WAIT_MAX = (RD_WAIT > WR_WAIT + 1) ? RD_WAIT : WR_WAIT + 1;
  localparam int unsigned CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT);

  state_e              r_state, w_nxt_state;
  logic [CNT_W-1:0]    r_cnt, w_nxt_cnt;
  req_t                r_req, w_req;
  logic [HA_W-1:0]     r_haddr, w_haddr;
  strb_t               r_strb, w_nxt_strb;
  logic [ADDR_W-1:0]   r_addr, w_nxt_addr;
  logic                r_dq_oe, w_nxt_dq_oe;
  logic [SRAM_DW-1:0]  r_dq_out, w_nxt_dq_out;
  logic [SRAM_DW-1:0]  r_rdlo, w_nxt_rdlo;
  logic [SRAM_DW-1:0]  w_dq_in;
  logic [WORD_W-1:0]   r_rdata, w_nxt_rdata;
  logic                r_rdy, r_rsp_vld;
  logic                w_accept, w_last, w_hi;
  logic [1:0]          w_lane_n;
  logic                w_unused;

  assign w_unused = ^{lsu.req_addr[WORD_W-1:ADDR_W+1], lsu.req_addr[1:0]};

  sram_dq_buf u_dq_buf (
    .i_oe   (r_dq_oe),
    .i_dout (r_dq_out),
    .o_din  (w_dq_in),
    .io_dq  (io_sram_dq)
  );

  // Next state, phase counter, read capture, and next values of every registered pin.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = '0;
    w_nxt_rdlo   = r_rdlo;
    w_nxt_rdata  = r_rdata;
    w_accept     = lsu.req_vld & r_rdy;
    w_req        = r_req;
    w_haddr      = r_haddr;
    if (w_accept) begin
      w_req.wren  = lsu.req_wren;
      w_req.wdata = lsu.req_wdata;
      w_req.bmask = lsu.req_bmask;
      w_haddr     = lsu.req_addr[ADDR_W:2];
    end
    w_last = (r_cnt == (r_req.wren ? WR_LAST : RD_LAST));

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_req.wren || (w_req.bmask[1:0] != 2'b00)) w_nxt_state = LO;
          else if (w_req.bmask[3:2] != 2'b00)             w_nxt_state = HI;
          else                                            w_nxt_state = RSP;
        end
      end
      LO: begin
        if (w_last) begin
          if (!r_req.wren) w_nxt_rdlo = w_dq_in;
          w_nxt_state = (r_req.wren && (r_req.bmask[3:2] == 2'b00)) ? RSP : HI;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      HI: begin
        if (w_last) begin
          if (!r_req.wren) w_nxt_rdata = {w_dq_in, r_rdlo};
          w_nxt_state = RSP;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      RSP:     w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase

    // Pins follow the state being entered so they switch on the same edge as the FSM.
    w_hi         = (w_nxt_state == HI);
    w_lane_n     = lane_n(w_req.bmask, w_hi);
    w_nxt_strb   = STRB_IDLE;
    w_nxt_addr   = r_addr;
    w_nxt_dq_oe  = 1'b0;
    w_nxt_dq_out = r_dq_out;
    if ((w_nxt_state == LO) || (w_nxt_state == HI)) begin
      w_nxt_addr      = {w_haddr, w_hi};
      w_nxt_strb.ce_n = 1'b0;
      if (w_req.wren) begin
        w_nxt_strb.we_n = (w_nxt_cnt >= WR_LAST);
        w_nxt_strb.ub_n = w_lane_n[1];
        w_nxt_strb.lb_n = w_lane_n[0];
        w_nxt_dq_oe     = 1'b1;
        w_nxt_dq_out    = w_hi ? w_req.wdata[31:16] : w_req.wdata[15:0];
      end else begin
        w_nxt_strb.oe_n = 1'b0;
        w_nxt_strb.lb_n = 1'b0;
        w_nxt_strb.ub_n = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_req     <= '0;
      r_haddr   <= '0;
      r_strb    <= STRB_IDLE;
      r_addr    <= '0;
      r_dq_oe   <= 1'b0;
      r_dq_out  <= '0;
      r_rdlo    <= '0;
      r_rdata   <= '0;
      r_rdy     <= 1'b1;
      r_rsp_vld <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_req     <= w_req;
      r_haddr   <= w_haddr;
      r_strb    <= w_nxt_strb;
      r_addr    <= w_nxt_addr;
      r_dq_oe   <= w_nxt_dq_oe;
      r_dq_out  <= w_nxt_dq_out;
      r_rdlo    <= w_nxt_rdlo;
      r_rdata   <= w_nxt_rdata;
      r_rdy     <= (w_nxt_state == IDLE);
      r_rsp_vld <= (w_nxt_state == RSP);
    end
  end

  assign o_sram_addr   = r_addr;
  assign o_sram_ce_n   = r_strb.ce_n;
  assign o_sram_we_n   = r_strb.we_n;
  assign o_sram_oe_n   = r_strb.oe_n;
  assign o_sram_lb_n   = r_strb.lb_n;
  assign o_sram_ub_n   = r_strb.ub_n;
  assign lsu.req_rdy   = r_rdy;
  assign lsu.rsp_vld   = r_rsp_vld;
  assign lsu.rsp_rdata = r_rdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: behavioural SRAM, vector table plus reset/parameter sequences.
module tb_sram_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance with a byte-lane SRAM model
  sram_if lsu();
  logic [17:0] sram_addr;
  logic        ce_n, we_n, oe_n, lb_n, ub_n;
  wire  [15:0] dq;
  logic [15:0] mem [0:1023] = '{default: 16'h0000};
  logic [15:0] rd_val;

  assign rd_val = mem[sram_addr[9:0]];
  assign dq = (!ce_n && !oe_n && we_n) ? rd_val : 16'hzzzz;

  sram_ctrl dut (
    .i_clk(clk), .i_rstn(rstn), .lsu(lsu),
    .o_sram_addr(sram_addr), .io_sram_dq(dq),
    .o_sram_ce_n(ce_n), .o_sram_we_n(we_n), .o_sram_oe_n(oe_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  // RD_WAIT=3 instance; its model returns {addr[7:0], cycles-at-this-address}
  sram_if lsu3();
  logic [17:0] sram_addr3, last3 = '1;
  logic        ce3_n, we3_n, oe3_n, lb3_n, ub3_n;
  wire  [15:0] dq3;
  logic [7:0]  k3 = 8'd0;

  assign dq3 = (!ce3_n && !oe3_n && we3_n) ? {sram_addr3[7:0], k3} : 16'hzzzz;

  sram_ctrl #(.ADDR_W(18), .RD_WAIT(3), .WR_WAIT(1)) dut3 (
    .i_clk(clk), .i_rstn(rstn), .lsu(lsu3),
    .o_sram_addr(sram_addr3), .io_sram_dq(dq3),
    .o_sram_ce_n(ce3_n), .o_sram_we_n(we3_n), .o_sram_oe_n(oe3_n),
    .o_sram_lb_n(lb3_n), .o_sram_ub_n(ub3_n)
  );

  always @(negedge clk) begin
    if (!oe3_n) begin
      if (sram_addr3 != last3) begin
        k3    <= 8'd1;
        last3 <= sram_addr3;
      end else begin
        k3 <= k3 + 8'd1;
      end
    end else begin
      k3    <= 8'd0;
      last3 <= '1;
    end
  end

  // Write-pulse monitor and SRAM array update
  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
    logic [1:0]  s;
    int          we;
  } ev_t;

  ev_t  ev_q[$];
  int   ce_cnt = 0;
  int   drv_rd = 0;
  logic prev_we_n = 1'b1;

  always @(negedge clk) begin
    if (!ce_n) ce_cnt++;
    if (!oe_n && dut.r_dq_oe) drv_rd++;
    if (!ce_n && !we_n) begin
      if (prev_we_n) ev_q.push_back('{a: sram_addr, d: dq, s: {lb_n, ub_n}, we: 1});
      else ev_q[ev_q.size()-1].we = ev_q[ev_q.size()-1].we + 1;
      if (!lb_n) mem[sram_addr[9:0]][7:0]  = dq[7:0];
      if (!ub_n) mem[sram_addr[9:0]][15:8] = dq[15:8];
    end
    prev_we_n = we_n;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    int          lat;
    logic [31:0] rdata;
    int          ce;
    int          nev;
    logic [17:0] a0; logic [15:0] d0; logic [1:0] s0;
    logic [17:0] a1; logic [15:0] d1; logic [1:0] s1;
  } vec_t;

  vec_t vt[12];

  task automatic apply(input vec_t v, input int idx);
    int ev0, ce0, drv0, n;
    bit got;
    string p;
    p    = $sformatf("v%0d", idx);
    ev0  = ev_q.size();
    ce0  = ce_cnt;
    drv0 = drv_rd;
    @(negedge clk);
    chk({p, ".rdy_idle"}, 32'(lsu.req_rdy), 32'd1);
    lsu.req_vld   = 1'b1;
    lsu.req_wren  = v.wren;
    lsu.req_addr  = v.addr;
    lsu.req_wdata = v.wdata;
    lsu.req_bmask = v.bmask;
    @(posedge clk);
    #1 lsu.req_vld = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (lsu.rsp_vld) got = 1'b1;
    end
    chk({p, ".lat"}, got ? 32'(n) : 32'hFFFF_FFFF, 32'(v.lat));
    chk({p, ".rdata"}, lsu.rsp_rdata, v.rdata);
    @(negedge clk);
    chk({p, ".rsp_pulse"}, 32'(lsu.rsp_vld), 32'd0);
    chk({p, ".rdy_after"}, 32'(lsu.req_rdy), 32'd1);
    chk({p, ".ce_cycles"}, 32'(ce_cnt - ce0), 32'(v.ce));
    chk({p, ".dq_drv_in_read"}, 32'(drv_rd - drv0), 32'd0);
    chk({p, ".nwrites"}, 32'(ev_q.size() - ev0), 32'(v.nev));
    if (v.nev >= 1 && ev_q.size() > ev0) begin
      chk({p, ".w0_addr"}, 32'(ev_q[ev0].a), 32'(v.a0));
      chk({p, ".w0_data"}, 32'(ev_q[ev0].d), 32'(v.d0));
      chk({p, ".w0_lbub"}, 32'(ev_q[ev0].s), 32'(v.s0));
      chk({p, ".w0_we_cyc"}, 32'(ev_q[ev0].we), 32'd1);
    end
    if (v.nev >= 2 && ev_q.size() > ev0 + 1) begin
      chk({p, ".w1_addr"}, 32'(ev_q[ev0+1].a), 32'(v.a1));
      chk({p, ".w1_data"}, 32'(ev_q[ev0+1].d), 32'(v.d1));
      chk({p, ".w1_lbub"}, 32'(ev_q[ev0+1].s), 32'(v.s1));
      chk({p, ".w1_we_cyc"}, 32'(ev_q[ev0+1].we), 32'd1);
    end
  endtask

  initial begin
    int  n;
    bit  got, seen;

    //           wren  addr           wdata          mask  lat rdata          ce nev a0      d0        s0     a1      d1        s1
    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 5, 32'h0000_0000, 4, 2, 18'h08, 16'hBEEF, 2'b00, 18'h09, 16'hDEAD, 2'b00};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 3, 32'hDEAD_BEEF, 2, 0, 18'h00, 16'h0,    2'b00, 18'h00, 16'h0,    2'b00};
    vt[2]  = '{1'b1, 32'h0000_0010, 32'h00AA_0000, 4'h4, 3, 32'hDEAD_BEEF, 2, 1, 18'h09, 16'h00AA, 2'b01, 18'h00, 16'h0,    2'b00};
    vt[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 3, 32'hDEAA_BEEF, 2, 0, 18'h00, 16'h0,    2'b00, 18'h00, 16'h0,    2'b00};
    vt[4]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1, 32'hDEAA_BEEF, 0, 0, 18'h00, 16'h0,    2'b00, 18'h00, 16'h0,    2'b00};
    vt[5]  = '{1'b1, 32'h0000_0024, 32'h1234_5678, 4'h3, 3, 32'hDEAA_BEEF, 2, 1, 18'h12, 16'h5678, 2'b00, 18'h00, 16'h0,    2'b00};
    vt[6]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 3, 32'h0000_5678, 2, 0, 18'h00, 16'h0,    2'b00, 18'h00, 16'h0,    2'b00};
    vt[7]  = '{1'b1, 32'h0000_0024, 32'hAABB_CCDD, 4'hA, 5, 32'h0000_5678, 4, 2, 18'h12, 16'hCCDD, 2'b10, 18'h13, 16'hAABB, 2'b10};
    vt[8]  = '{1'b0, 32'hFFF8_0027, 32'h0,         4'h0, 3, 32'hAA00_CC78, 2, 0, 18'h00, 16'h0,    2'b00, 18'h00, 16'h0,    2'b00};
    vt[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 3, 32'hDEAA_BEEF, 2, 0, 18'h00, 16'h0,    2'b00, 18'h00, 16'h0,    2'b00};
    vt[10] = '{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 5, 32'h0000_0000, 4, 2, 18'h18, 16'hF00D, 2'b00, 18'h19, 16'hCAFE, 2'b00};
    vt[11] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 3, 32'hCAFE_F00D, 2, 0, 18'h00, 16'h0,    2'b00, 18'h00, 16'h0,    2'b00};

    lsu.req_vld  = 1'b0; lsu.req_wren  = 1'b0; lsu.req_addr  = '0; lsu.req_wdata  = '0; lsu.req_bmask  = '0;
    lsu3.req_vld = 1'b0; lsu3.req_wren = 1'b0; lsu3.req_addr = '0; lsu3.req_wdata = '0; lsu3.req_bmask = '0;

    // Reset values
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.rdy", 32'(lsu.req_rdy), 32'd1);
    chk("rst.rsp_vld", 32'(lsu.rsp_vld), 32'd0);
    chk("rst.rdata", lsu.rsp_rdata, 32'd0);
    chk("rst.addr", 32'(sram_addr), 32'd0);
    chk("rst.strobes", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1F);
    chk("rst.dq_oe", 32'(dut.r_dq_oe), 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) apply(vt[i], i);

    // Longer read wait states
    @(negedge clk);
    lsu3.req_vld = 1'b1; lsu3.req_wren = 1'b0; lsu3.req_addr = 32'h0000_0040;
    @(posedge clk);
    #1 lsu3.req_vld = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (lsu3.rsp_vld) got = 1'b1;
    end
    chk("rw3.lat", got ? 32'(n) : 32'hFFFF_FFFF, 32'd7);
    chk("rw3.rdata", lsu3.rsp_rdata, 32'h2103_2003);

    // Reset in the HI phase of a read
    @(negedge clk);
    lsu.req_vld = 1'b1; lsu.req_wren = 1'b0; lsu.req_addr = 32'h0000_0010;
    @(posedge clk);
    #1 lsu.req_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.hi_addr", 32'(sram_addr), 32'h9);
    chk("mid.hi_oe_n", 32'(oe_n), 32'd0);
    #1 rstn = 1'b0;
    #1;
    chk("mid.strobes", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1F);
    chk("mid.dq_oe", 32'(dut.r_dq_oe), 32'd0);
    chk("mid.rdy", 32'(lsu.req_rdy), 32'd1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (lsu.rsp_vld) seen = 1'b1;
    end
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (lsu.rsp_vld) seen = 1'b1;
    end
    chk("mid.no_rsp", 32'(seen), 32'd0);
    chk("mid.rdy_after", 32'(lsu.req_rdy), 32'd1);

    for (int i = 10; i < 12; i++) apply(vt[i], i);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
